// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multi-cycle control unit: opcodes, FSM states,
// ALUOp codes and datapath mux selects.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_RWB    = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_TRAP   = 4'd11
  } state_t;

  // Same 2-bit encoding the ALU-op mapper already consumes.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-line decode: Moore outputs of the FSM state, with the
// FETCH-cycle IR/PC loads qualified by the memory ready handshake.
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_op        = ALUOP_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    case (state_t'(state))
      ST_FETCH: begin
        // PC+4 is computed every fetch cycle but only committed with the IR.
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
      end
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      ST_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, next-state sequencing, retired
// instruction counter and sticky illegal-opcode flag.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             ir_write,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  state_t state, next_state;
  logic   retire_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   next_state = ST_FETCH;
      ST_FETCH:  if (mem_ready) next_state = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     next_state = ST_EXEC;
          OP_LW, OP_SW: next_state = ST_MEMADR;
          OP_BEQ:       next_state = ST_BRANCH;
          OP_J:         next_state = ST_JUMP;
          default:      next_state = ST_TRAP;
        endcase
      end
      ST_MEMADR: begin
        // Opcode is still live here; anything other than lw/sw is a trap.
        if (opcode == OP_LW)      next_state = ST_MEMRD;
        else if (opcode == OP_SW) next_state = ST_MEMWR;
        else                      next_state = ST_TRAP;
      end
      ST_MEMRD:  if (mem_ready) next_state = ST_MEMWB;
      ST_MEMWB:  next_state = ST_FETCH;
      ST_MEMWR:  if (mem_ready) next_state = ST_FETCH;
      ST_EXEC:   next_state = ST_RWB;
      ST_RWB:    next_state = ST_FETCH;
      ST_BRANCH: next_state = ST_FETCH;
      ST_JUMP:   next_state = ST_FETCH;
      ST_TRAP:   next_state = ST_TRAP;
      default:   next_state = ST_IDLE;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  assign retire_now = (state == ST_RWB) || (state == ST_MEMWB) ||
                      (state == ST_BRANCH) || (state == ST_JUMP) ||
                      ((state == ST_MEMWR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired    <= '0;
      illegal_op <= 1'b0;
    end else begin
      if (retire_now)              retired    <= retired + CNT_W'(1);
      if (next_state == ST_TRAP)   illegal_op <= 1'b1;
    end
  end

  assign state_dbg = state;

  mc_ctrl_decode u_decode (
    .state         (state),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .ir_write      (ir_write),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst)
  );

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Sequential multi-cycle control unit for the MIPS datapath. It is the issuing counterpart of the single-cycle opcode decoder.
- Walks each instruction through fetch, decode, execute, memory and writeback states and drives the datapath control lines cycle by cycle.
- Memory accesses use a ready handshake. The block emits the same 2-bit ALUOp encoding consumed by the existing ALU-op mapper.
- Supports R-format, lw, sw, beq and j. Any other opcode traps.

Parameters:
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]; stable from DECODE until the instruction retires
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_to_reg  out  1  writeback select: 1=MDR
ir_write  out  1  IR load
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
alu_op  out  2  00=add, 01=sub, 10=use funct
alu_src_a  out  1  0=PC, 1=regA
alu_src_b  out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
reg_write  out  1  register file write
reg_dst  out  1  1=rd, 0=rt
illegal_op  out  1  sticky trap flag
retired  out  CNT_W  count of completed instructions
state_dbg  out  4  current state code

Behaviour:
- Reset is asynchronous. While rst_n=0:
  - state is IDLE; every control output is 0.
  - retired=0 and illegal_op=0.
  - Takes effect immediately, including mid-instruction.
  - A memory request in flight is dropped.
- On the first rising edge after rst_n rises, IDLE goes to FETCH.
- State encoding (4 bits): IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, TRAP=11.
- Outputs are Moore outputs of state, except ir_write and pc_write in FETCH, which are gated by mem_ready. All outputs not listed for a state are 0.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode: 000000 to EXEC; 100011 or 101011 to MEMADR; 000100 to BRANCH; 000010 to JUMP; anything else to TRAP.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - lw goes to MEMRD; sw goes to MEMWR.
- MEMRD:
  - Outputs: mem_read=1, iord=1.
  - Held until mem_ready=1, then goes to MEMWB.
- MEMWB:
  - Outputs: reg_write=1, mem_to_reg=1, reg_dst=0.
  - Goes to FETCH.
- MEMWR:
  - Outputs: mem_write=1, iord=1.
  - Held until mem_ready=1, then goes to FETCH.
- EXEC:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Goes to RWB.
- RWB:
  - Outputs: reg_write=1, reg_dst=1, mem_to_reg=0.
  - Goes to FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - Goes to FETCH.
- JUMP:
  - Outputs: pc_write=1, pc_source=10.
  - Goes to FETCH.
- TRAP:
  - All controls 0; illegal_op=1.
  - Stays in TRAP until reset.
- Latency with mem_ready tied high: R=4 cycles, lw=5, sw=4, beq=3, j=3. Each wait cycle on mem_ready adds one cycle.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- retired increments on the clock edge leaving any of RWB, MEMWB, MEMWR (with mem_ready=1), BRANCH, JUMP. It wraps modulo 2^CNT_W and never increments in TRAP.
- Opcode changes outside DECODE/MEMADR have no effect.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J);
  - state encodings;
  - ALUOp codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - pc_source and alu_src_b codes.
- One sub-module is natural: mc_ctrl_decode, combinational (state, mem_ready) to all control outputs.
- The top module holds the state register, the next-state logic, the counter and the trap flag.

Test Plan:
- Reset then opcode=000000, mem_ready=1 → after IDLE, states FETCH, DECODE, EXEC, RWB; alu_op=10 in EXEC; reg_write=1 and reg_dst=1 in RWB; retired 0→1.
- lw (100011) with mem_ready low 2 cycles in MEMRD → mem_read=1 and iord=1 held 3 cycles; MEMWB has mem_to_reg=1; total 7 cycles; retired +1.
- sw (101011) then beq (000100), mem_ready=1 → MEMWR has mem_write=1 for 1 cycle; BRANCH has alu_op=01, pc_write_cond=1, pc_source=01; retired +2.
- FETCH with mem_ready=0 for 3 cycles → ir_write=pc_write=0 throughout; both go to 1 only in the ready cycle.
- opcode=111111 at DECODE → TRAP, illegal_op=1 and held, all controls 0, retired frozen; pulse rst_n low mid-state → state_dbg=0 and illegal_op=0 immediately, no clock needed.
- Preload 2^16−1 retired via back-to-back j (000010) → counter wraps to 0; each j takes 3 cycles with pc_source=10.
